// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: START, STOP, WRITE and READ commands, one at a time, on
// open-drain SCL/SDA. Each bit is four quarters, and each quarter lasts CLK_DIV clocks.
module i2c_byte_engine #(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [1:0]  OP_START = 2'b00;
  localparam logic [1:0]  OP_STOP  = 2'b01;
  localparam logic [1:0]  OP_WRITE = 2'b10;
  localparam logic [1:0]  OP_READ  = 2'b11;
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, STOP, WBIT, WACK, RBIT, RACK} state_t;

  state_t      state_q, state_d;
  logic [11:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        nack_q, nack_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_s_q, ack_s_d;
  logic        in_txn_q, in_txn_d;
  logic        err_pend_q, err_pend_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_ack_q, rsp_ack_d;
  logic        rsp_err_q, rsp_err_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic [1:0]  sync_q, sync_d;
  logic        qtr_end;
  logic        done;

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    data_d      = data_q;
    nack_d      = nack_q;
    shift_d     = shift_q;
    ack_s_d     = ack_s_q;
    in_txn_d    = in_txn_q;
    err_pend_d  = err_pend_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ack_d   = rsp_ack_q;
    rsp_err_d   = rsp_err_q;
    sync_d      = {sync_q[0], sda_in};
    done        = 1'b0;
    qtr_end     = (div_q == DIV_LAST);

    if (state_q == IDLE) begin
      if (err_pend_q) begin
        // A rejected command completes one cycle after accept and never touches the bus.
        err_pend_d  = 1'b0;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_data_d  = 8'h00;
        rsp_ack_d   = 1'b0;
      end else if (cmd_valid && cmd_ready_q) begin
        data_d  = cmd_data;
        nack_d  = cmd_nack;
        div_d   = '0;
        qtr_d   = '0;
        bit_d   = '0;
        shift_d = '0;
        ack_s_d = 1'b0;
        busy_d  = 1'b1;
        case (cmd_op)
          OP_START: state_d = START;
          OP_STOP:  if (in_txn_q) state_d = STOP; else err_pend_d = 1'b1;
          OP_WRITE: if (in_txn_q) state_d = WBIT; else err_pend_d = 1'b1;
          OP_READ:  if (in_txn_q) state_d = RBIT; else err_pend_d = 1'b1;
          default:  err_pend_d = 1'b1;
        endcase
      end
    end else begin
      div_d = qtr_end ? '0 : div_q + 12'd1;
      if (qtr_end) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd2) begin
          if (state_q == WACK) ack_s_d = sync_q[1];
          if (state_q == RBIT) shift_d = {shift_q[6:0], sync_q[1]};
        end
        if (qtr_q == 2'd3) begin
          case (state_q)
            START: begin in_txn_d = 1'b1; done = 1'b1; end
            STOP:  begin in_txn_d = 1'b0; done = 1'b1; end
            WBIT: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = WACK;
            end
            RBIT: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = RACK;
            end
            default: done = 1'b1;
          endcase
        end
      end
    end

    if (done) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = (state_q == RACK) ? shift_q : 8'h00;
      rsp_ack_d   = (state_q == WACK) && ack_s_q;
    end

    cmd_ready_d = (state_d == IDLE) && !busy_d;
  end

  // Line levels are decoded from the next state so they are registered and glitch-free.
  always_comb begin
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    case (state_d)
      IDLE: begin
        if (in_txn_d) begin
          scl_oe_d = 1'b1;
        end else begin
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
        end
      end
      START: begin
        case (qtr_d)
          2'd0:    sda_oe_d = 1'b0;
          2'd1:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
          2'd2:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
          default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
        endcase
      end
      STOP: begin
        case (qtr_d)
          2'd0:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
          2'd3:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
          default: begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
        endcase
      end
      WBIT: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = ~data_d[3'd7 - bit_d];
      end
      RACK: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = ~nack_d;
      end
      default: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      nack_q      <= 1'b0;
      shift_q     <= '0;
      ack_s_q     <= 1'b0;
      in_txn_q    <= 1'b0;
      err_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ack_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      nack_q      <= nack_d;
      shift_q     <= shift_d;
      ack_s_q     <= ack_s_d;
      in_txn_q    <= in_txn_d;
      err_pend_q  <= err_pend_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_err_q   <= rsp_err_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      sync_q      <= sync_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ack   = rsp_ack_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Self-checking bench for i2c_byte_engine: a scoreboard of expected responses plus
// per-cycle traces of scl_oe/sda_oe checked against the quarter-by-quarter line sequence.
module tb_i2c_byte_engine;

  localparam int CLK_DIV = 4;
  localparam int QB      = 4 * CLK_DIV;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op   = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       rsp_err;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] tr [0:255];
  int         checks = 0;
  int         errors = 0;

  // Slave model: mode 1 pulls ACK in the ninth bit, mode 2 drives slave_byte MSB first.
  int         acc_cyc = 1000;
  int         sl_bit;
  logic [1:0] slave_mode = 2'd0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] sl_shift;
  logic       slave_low;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (cmd_valid && cmd_ready) acc_cyc <= 0;
    else if (acc_cyc < 100000)  acc_cyc <= acc_cyc + 1;
  end

  always_comb begin
    sl_bit    = acc_cyc / QB;
    sl_shift  = slave_byte << sl_bit;
    slave_low = 1'b0;
    if (slave_mode == 2'd1)      slave_low = (sl_bit == 8);
    else if (slave_mode == 2'd2) slave_low = (sl_bit < 8) && !sl_shift[7];
  end

  assign sda_in = ~(sda_oe | slave_low);

  i2c_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_nack (cmd_nack),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ack  (rsp_ack),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in)
  );

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic n);
    int w;
    w = 0;
    @(negedge CLOCK_50);
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge CLOCK_50);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_nack  = n;
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    tr[0] = {scl_oe, sda_oe};
  endtask

  task automatic wait_rsp(input string name);
    exp_t e;
    int   k;
    logic hs_bad;
    logic [7:0] d0;
    logic a0, r0;
    k = 0;
    hs_bad = (cmd_ready !== 1'b0) || (busy !== 1'b1);
    while (rsp_valid !== 1'b1 && k < 200) begin
      @(posedge CLOCK_50);
      #1;
      k++;
      tr[k] = {scl_oe, sda_oe};
      if (rsp_valid !== 1'b1 && (cmd_ready !== 1'b0 || busy !== 1'b1)) hs_bad = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || k != e.lat) begin
      errors++;
      $display("FAIL %s_latency: rsp_valid=%b after %0d cycles, required %0d", name, rsp_valid, k, e.lat);
    end
    checks++;
    if ({rsp_data, rsp_ack, rsp_err} !== {e.data, e.ack, e.err}) begin
      errors++;
      $display("FAIL %s_rsp: data=%h ack=%b err=%b, required data=%h ack=%b err=%b",
               name, rsp_data, rsp_ack, rsp_err, e.data, e.ack, e.err);
    end
    checks++;
    if (hs_bad || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: busy=%b cmd_ready=%b at rsp_valid, in-flight violation=%b",
               name, busy, cmd_ready, hs_bad);
    end
    d0 = rsp_data; a0 = rsp_ack; r0 = rsp_err;
    @(posedge CLOCK_50);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || {rsp_data, rsp_ack, rsp_err} !== {d0, a0, r0}) begin
      errors++;
      $display("FAIL %s_pulse: rsp_valid=%b fields=%h/%b/%b, required 0 with fields held",
               name, rsp_valid, rsp_data, rsp_ack, rsp_err);
    end
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] d, input logic n,
                        input logic [7:0] xd, input logic xa, input logic xe, input int lat);
    exp_t e;
    e.data = xd; e.ack = xa; e.err = xe; e.lat = lat;
    sb.push_back(e);
    issue(op, d, n);
    wait_rsp(name);
  endtask

  // Line state in the middle of each quarter of a 4-quarter command, then the idle level after it.
  task automatic check_quarters(input string name, input logic [9:0] exp_lines);
    logic [9:0] got;
    got = {tr[1], tr[5], tr[9], tr[13], tr[16]};
    checks++;
    if (got !== exp_lines) begin
      errors++;
      $display("FAIL %s_lines: scl/sda per quarter=%b required %b", name, got, exp_lines);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if ({scl_oe, sda_oe, cmd_ready, rsp_valid, busy, rsp_data, rsp_ack, rsp_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: scl=%b sda=%b ready=%b valid=%b busy=%b data=%h ack=%b err=%b, required all 0",
               scl_oe, sda_oe, cmd_ready, rsp_valid, busy, rsp_data, rsp_ack, rsp_err);
    end
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] ops [3];
    ops[0] = OP_WRITE; ops[1] = OP_READ; ops[2] = OP_STOP;
    for (int i = 0; i < 3; i++) begin
      do_cmd("illegal", ops[i], 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1);
      checks++;
      if ({tr[0], tr[1]} !== 4'b0000) begin
        errors++;
        $display("FAIL illegal_bus op=%0d: lines=%b required 0000", ops[i], {tr[0], tr[1]});
      end
    end
  endtask

  task automatic test_start;
    do_cmd("start", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
    check_quarters("start", 10'b00_00_01_11_11);
  endtask

  task automatic test_write;
    logic [7:0] byte_v;
    logic       s;
    byte_v = 8'hE0;
    slave_mode = 2'd1;
    do_cmd("write_e0", OP_WRITE, byte_v, 1'b0, 8'h00, 1'b0, 1'b0, 9 * QB);
    slave_mode = 2'd0;
    for (int b = 0; b < 9; b++) begin
      s = (b < 8) ? ~byte_v[7 - b] : 1'b0;
      checks++;
      if ({tr[b*QB+1][1], tr[b*QB+9][1], tr[b*QB+1][0], tr[b*QB+13][0]} !== {1'b1, 1'b0, s, s}) begin
        errors++;
        $display("FAIL write_bit%0d: sclq0=%b sclq2=%b sdaq0=%b sdaq3=%b required 1 0 %b %b",
                 b, tr[b*QB+1][1], tr[b*QB+9][1], tr[b*QB+1][0], tr[b*QB+13][0], s, s);
      end
    end
  endtask

  task automatic test_read_stop;
    logic sda_seen;
    slave_mode = 2'd2;
    slave_byte = 8'hA5;
    do_cmd("read_a5", OP_READ, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 9 * QB);
    slave_mode = 2'd0;
    sda_seen = 1'b0;
    for (int k = 1; k < 9 * QB; k++) sda_seen |= tr[k][0];
    checks++;
    if (sda_seen !== 1'b0) begin
      errors++;
      $display("FAIL read_sda_release: sda_oe asserted during read/RACK=%b required 0", sda_seen);
    end
    do_cmd("stop", OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
    check_quarters("stop", 10'b11_01_01_00_00);
  endtask

  task automatic test_repeated_start;
    do_cmd("rs_start", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
    do_cmd("rs_write_nack", OP_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 9 * QB);
    do_cmd("rs_restart", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
    check_quarters("rs_restart", 10'b10_00_01_11_11);
    do_cmd("rs_write2", OP_WRITE, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 9 * QB);
    do_cmd("rs_stop", OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    logic stray;
    e.data = 8'h00; e.ack = 1'b0; e.err = 1'b0; e.lat = QB;
    sb.push_back(e);
    issue(OP_START, 8'h00, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_data  = 8'hFF;
    fork
      begin
        repeat (8) @(negedge CLOCK_50);
        cmd_valid = 1'b0;
      end
    join_none
    wait_rsp("busy_ignore");
    stray = 1'b0;
    repeat (20) begin
      @(posedge CLOCK_50);
      #1;
      stray |= rsp_valid | busy;
    end
    checks++;
    if (stray !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL busy_queueing: stray activity=%b pending=%0d required 0/0", stray, sb.size());
    end
    do_cmd("busy_stop", OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
  endtask

  task automatic test_reset_mid;
    do_cmd("rm_start", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, QB);
    issue(OP_WRITE, 8'h55, 1'b0);
    repeat (10 * CLK_DIV) @(posedge CLOCK_50);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, busy, cmd_ready, rsp_valid} !== 5'd0) begin
      errors++;
      $display("FAIL reset_async: scl=%b sda=%b busy=%b ready=%b valid=%b required all 0",
               scl_oe, sda_oe, busy, cmd_ready, rsp_valid);
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b scl=%b sda=%b required 1 0 0", cmd_ready, scl_oe, sda_oe);
    end
    do_cmd("rm_after", OP_WRITE, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_start();
    test_write();
    test_read_stop();
    test_repeated_start();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_engine.md
I2C_BYTE_ENGINE -- requirements
Module: i2c_byte_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving CLOCK_50 cycles per quarter-bit (125 gives 100 kHz SCL); legal range 2..4095.
REQ-002 SHALL have port CLOCK_50, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, engine accepts a command this cycle.
REQ-006 SHALL have port cmd_op, input, 2: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-007 SHALL have port cmd_data, input, 8, the byte for WRITE.
REQ-008 SHALL have port cmd_nack, input, 1, the ack bit driven after READ (1 = NACK).
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rsp_data, output, 8, the byte received by READ; 0x00 for other ops.
REQ-011 SHALL have port rsp_ack, output, 1, the ack bit sampled after WRITE (0 = ACK); 0 for other ops.
REQ-012 SHALL have port rsp_err, output, 1, set when a command is illegal in the current bus state.
REQ-013 SHALL have port busy, output, 1, high from accept until rsp_valid.
REQ-014 SHALL have port scl_oe, output, 1, drives SCL low when 1, releases it when 0.
REQ-015 SHALL have port sda_oe, output, 1, drives SDA low when 1, releases it when 0.
REQ-016 SHALL have port sda_in, input, 1, asynchronous SDA line level.

Function
REQ-017 SHALL accept a command on a rising edge with cmd_valid && cmd_ready.
- cmd_ready deasserts the next cycle.
- cmd_op, cmd_data and cmd_nack are registered at accept.
REQ-018 SHALL synchronise sda_in through two flops before any use.
REQ-019 SHALL restart the quarter counter at accept and advance one quarter every CLK_DIV cycles.
- START and STOP last 4 quarters.
- WRITE and READ last 36 quarters (9 bits x 4).
REQ-020 SHALL pulse rsp_valid exactly N*CLK_DIV cycles after the accepting edge, N being the quarter count.
- cmd_ready reasserts and busy falls in the same cycle.
- rsp_data, rsp_ack and rsp_err hold until the next rsp_valid.
REQ-021 SHALL use the states IDLE, START, STOP, WBIT, WACK, RBIT, RACK.
- IDLE -> op state on accept.
- WBIT x8 -> WACK -> IDLE.
- RBIT x8 -> RACK -> IDLE.
- START and STOP -> IDLE.
REQ-022 SHALL sequence START quarters as follows.
- q0: SDA released, SCL unchanged.
- q1: SDA released, SCL released.
- q2: SDA low, SCL released.
- q3: SDA low, SCL low.
- Afterwards the in_txn flag is set.
REQ-023 SHALL sequence STOP quarters as follows.
- q0: SDA low, SCL low.
- q1 and q2: SDA low, SCL released.
- q3: both released.
- Afterwards in_txn is cleared.
REQ-024 SHALL shape each data/ack bit as follows.
- q0 and q1: SCL low, SDA set at q0 start.
- q2 and q3: SCL released.
- Sampling occurs on the synchronised SDA at the q2->q3 boundary.
REQ-025 WRITE SHALL send cmd_data MSB first (sda_oe = ~bit), release SDA during WACK, and latch the sampled bit into rsp_ack.
REQ-026 READ SHALL release SDA for 8 bits, shift samples MSB first into rsp_data, and drive sda_oe = ~cmd_nack during RACK.
REQ-027 START issued while in_txn=1 SHALL produce a repeated start per REQ-022 and leave in_txn set.
REQ-028 WRITE, READ or STOP issued while in_txn=0 SHALL make no bus activity and assert rsp_valid with rsp_err=1 in the cycle after accept.
REQ-029 SHALL hold SCL low (scl_oe=1) between commands while in_txn=1, with SDA at its last driven level.
REQ-030 SHALL release both lines (scl_oe=0, sda_oe=0) while idle with in_txn=0.
REQ-031 SHALL ignore cmd_valid while busy; no command queueing.

Reset
REQ-032 SHALL, on rst_n low, immediately set the following without generating STOP:
- scl_oe=0, sda_oe=0.
- cmd_ready=0, rsp_valid=0, rsp_data=0x00, rsp_ack=0, rsp_err=0, busy=0.
- in_txn=0, state IDLE, counters 0.
REQ-033 SHALL assert cmd_ready on the first clock edge after rst_n deasserts.

Verification (CLK_DIV=4)
REQ-034 START from idle -> SDA falls while SCL released, rsp_valid at cycle 16 after accept, rsp_err=0.
REQ-035 START, then WRITE 0xE0 with slave pulling ACK low -> sda_oe over bits 0,0,0,1,1,1,1,1, released in bit 9; rsp_ack=0, rsp_valid 144 cycles after accept.
REQ-036 READ with slave driving 0xA5 and cmd_nack=1 -> rsp_data=0xA5, sda_oe=0 throughout RACK, then STOP leaves both lines released.
REQ-037 WRITE 0x55 with no prior START -> no scl_oe/sda_oe activity, rsp_valid one cycle after accept, rsp_err=1.
REQ-038 rst_n pulsed low at quarter 10 of a WRITE -> scl_oe=sda_oe=0 asynchronously, cmd_ready=1 one cycle after release.
REQ-039 START, WRITE, START (repeated) -> SDA released before SCL rises, SDA falls with SCL high, in_txn stays 1.
